// File: rtl/transfer_scheduler_if.sv
// Scanner/remote-center bundle for transfer_scheduler.
// The scheduler takes the slave modport; the scanners and remote center drive it through the master modport.
interface transfer_scheduler_if;
    logic [1:0] scanReq;
    logic [7:0] scanByte0;
    logic [7:0] scanByte1;
    logic [1:0] scanGrant;
    logic       readyForTransferIn;
    logic       readyForTransferOut;
    logic       dataOut;
    logic [1:0] localScannerOut;
    logic       busy;

    modport slave (
        input  scanReq, scanByte0, scanByte1, readyForTransferIn,
        output scanGrant, readyForTransferOut, dataOut, localScannerOut, busy
    );

    modport master (
        output scanReq, scanByte0, scanByte1, readyForTransferIn,
        input  scanGrant, readyForTransferOut, dataOut, localScannerOut, busy
    );
endinterface

// File: rtl/transfer_scheduler.sv
// Round-robin arbiter between two scanners that serialises the granted byte MSB-first onto one data line.
// Define TRANSFER_PARITY_EN to append an even-parity bit after bit 0 of every frame.
module transfer_scheduler #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    transfer_scheduler_if.slave   bus
);

`ifdef TRANSFER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd3} state_t;
`endif

    localparam logic [3:0] LAST_CYC = 4'(BIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] cyc_q, cyc_d;
    logic [2:0] bit_q, bit_d;
    logic       lastServed_q, lastServed_d;
    logic [1:0] grant_q, grant_d;
    logic       rfo_q, rfo_d;
    logic [1:0] owner_q, owner_d;
    logic       busy_q, busy_d;
`ifdef TRANSFER_PARITY_EN
    logic       parity_q, parity_d;
`endif

    logic       winner;
    logic [7:0] capByte;

    // On a tie the scanner that was not served last wins.
    always_comb begin
        winner = ~lastServed_q;
        if (bus.scanReq == 2'b01)
            winner = 1'b0;
        else if (bus.scanReq == 2'b10)
            winner = 1'b1;
        capByte = winner ? bus.scanByte1 : bus.scanByte0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= 8'd0;
            cyc_q        <= 4'd0;
            bit_q        <= 3'd0;
            lastServed_q <= 1'b1;
            grant_q      <= 2'b00;
            rfo_q        <= 1'b0;
            owner_q      <= 2'b00;
            busy_q       <= 1'b0;
`ifdef TRANSFER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cyc_q        <= cyc_d;
            bit_q        <= bit_d;
            lastServed_q <= lastServed_d;
            grant_q      <= grant_d;
            rfo_q        <= rfo_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
`ifdef TRANSFER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Everything holds by default, which is also how a stall freezes the frame.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cyc_d        = cyc_q;
        bit_d        = bit_q;
        lastServed_d = lastServed_q;
        grant_d      = 2'b00;
        rfo_d        = rfo_q;
        owner_d      = owner_q;
        busy_d       = busy_q;
`ifdef TRANSFER_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.scanReq != 2'b00 && bus.readyForTransferIn) begin
                    state_d      = SEND;
                    shift_d      = capByte;
                    cyc_d        = 4'd0;
                    bit_d        = 3'd0;
                    lastServed_d = winner;
                    grant_d      = winner ? 2'b10 : 2'b01;
                    owner_d      = winner ? 2'b10 : 2'b01;
                    rfo_d        = 1'b1;
                    busy_d       = 1'b1;
`ifdef TRANSFER_PARITY_EN
                    parity_d     = ^capByte;
`endif
                end
            end
            SEND: begin
                if (bus.readyForTransferIn) begin
                    if (cyc_q == LAST_CYC) begin
                        cyc_d   = 4'd0;
                        bit_d   = bit_q + 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                        if (bit_q == 3'd7) begin
`ifdef TRANSFER_PARITY_EN
                            state_d = PAR;
                            shift_d = {parity_q, 7'd0};
`else
                            state_d = DONE;
                            rfo_d   = 1'b0;
                            owner_d = 2'b00;
`endif
                        end
                    end else begin
                        cyc_d = cyc_q + 4'd1;
                    end
                end
            end
`ifdef TRANSFER_PARITY_EN
            PAR: begin
                if (bus.readyForTransferIn) begin
                    if (cyc_q == LAST_CYC) begin
                        cyc_d   = 4'd0;
                        shift_d = 8'd0;
                        state_d = DONE;
                        rfo_d   = 1'b0;
                        owner_d = 2'b00;
                    end else begin
                        cyc_d = cyc_q + 4'd1;
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The shift register is empty outside a frame, so its MSB doubles as the idle-low data line.
    assign bus.scanGrant           = grant_q;
    assign bus.readyForTransferOut = rfo_q;
    assign bus.dataOut             = shift_q[7];
    assign bus.localScannerOut     = owner_q;
    assign bus.busy                = busy_q;

endmodule

// File: tb/tb_transfer_scheduler.sv
// Randomised scoreboard bench for transfer_scheduler: a frame-level model predicts grants and frames,
// a negedge monitor reassembles serial frames and compares them against the expected queue.
module tb_transfer_scheduler;
    localparam int BC = 2;
`ifdef TRANSFER_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif
    localparam int FLEN       = NBITS * BC;
    localparam int RUN_CYCLES = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    transfer_scheduler_if bus();

    transfer_scheduler #(.BIT_CYCLES(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int         nChecks = 0;
    int         nFail   = 0;
    int         expFrameQ[$];
    int         mPhase  = 0;
    int         mLeft   = 0;
    int         mLast   = 1;
    logic [1:0] mGrantExp   = 2'b00;
    logic [1:0] grantedMask = 2'b00;
    int         curW        = 0;
    logic [7:0] curByte     = 8'd0;
    int         framesSeen  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_grant"},    int'(bus.scanGrant), 0);
        checkOutput({tag, "_readyOut"}, int'(bus.readyForTransferOut), 0);
        checkOutput({tag, "_dataOut"},  int'(bus.dataOut), 0);
        checkOutput({tag, "_owner"},    int'(bus.localScannerOut), 0);
        checkOutput({tag, "_busy"},     int'(bus.busy), 0);
    endtask

    // Frame-level reference: phase 0 idle, 1 frame on the wire with mLeft active cycles to go, 2 closing cycle.
    task automatic modelStep();
        mGrantExp = 2'b00;
        case (mPhase)
            0: begin
                if (bus.scanReq != 2'b00 && bus.readyForTransferIn) begin
                    int w;
                    if (bus.scanReq == 2'b01)      w = 0;
                    else if (bus.scanReq == 2'b10) w = 1;
                    else                           w = (mLast == 1) ? 0 : 1;
                    mLast   = w;
                    curW    = w;
                    curByte = (w == 1) ? bus.scanByte1 : bus.scanByte0;
                    expFrameQ.push_back(w * 256 + int'(curByte));
                    mGrantExp      = (w == 1) ? 2'b10 : 2'b01;
                    grantedMask[w] = 1'b1;
                    mPhase = 1;
                    mLeft  = FLEN;
                end
            end
            1: begin
                if (bus.readyForTransferIn) begin
                    mLeft--;
                    if (mLeft == 0) mPhase = 2;
                end
            end
            default: mPhase = 0;
        endcase
    endtask

    task automatic applyStimulus(input bit allowNew);
        logic [1:0] req;
        req = bus.scanReq;
        for (int i = 0; i < 2; i++) begin
            if (grantedMask[i]) begin
                req[i]         = 1'b0;
                grantedMask[i] = 1'b0;
            end else if (allowNew && !req[i] && $urandom_range(0, 3) == 0) begin
                req[i] = 1'b1;
                if (i == 0) bus.scanByte0 = 8'($urandom);
                else        bus.scanByte1 = 8'($urandom);
            end
        end
        bus.scanReq            = req;
        bus.readyForTransferIn = ($urandom_range(0, 7) != 0);
    endtask

    task automatic stepCycle(input bit allowNew);
        @(posedge clk);
        modelStep();
        #1 applyStimulus(allowNew);
    endtask

    // Abort a frame a few bits in; the owning scanner keeps requesting the same byte.
    task automatic injectReset();
        int waited = 0;
        while (!(mPhase == 1 && mLeft <= FLEN - 4 * BC && mLeft > FLEN - 6 * BC) && waited < 400) begin
            stepCycle(1'b1);
            waited++;
        end
        checkOutput("resetWindowReached", (waited < 400) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1 checkResetValues("asyncReset");
        mPhase      = 0;
        mLast       = 1;
        mGrantExp   = 2'b00;
        grantedMask = 2'b00;
        expFrameQ.delete();
        if (curW == 1) bus.scanByte1 = curByte;
        else           bus.scanByte0 = curByte;
        bus.scanReq[curW]      = 1'b1;
        bus.readyForTransferIn = 1'b1;
        repeat (2) @(posedge clk);
        #1 checkResetValues("heldReset");
        rst_n = 1'b1;
    endtask

    int         nS        = 0;
    int         gap       = 0;
    bit         inFrame   = 1'b0;
    bit         seenFrame = 1'b0;
    bit         ownerBad  = 1'b0;
    logic [1:0] frOwner   = 2'b00;
    logic       samples[64];

    task automatic frameCheck();
        int         e;
        int         w;
        logic [7:0] got;
        logic [7:0] exByte;
        bit         consistent;
        framesSeen++;
        if (expFrameQ.size() == 0) begin
            checkOutput("frameExpected", 0, 1);
            return;
        end
        e          = expFrameQ.pop_front();
        w          = e / 256;
        exByte     = 8'(e % 256);
        got        = 8'd0;
        consistent = 1'b1;
        checkOutput("frameLen", nS, FLEN);
        checkOutput("frameOwner", int'(frOwner), (w == 1) ? 2 : 1);
        checkOutput("ownerStable", int'(ownerBad), 0);
        for (int k = 0; k < NBITS; k++) begin
            for (int j = 0; j < BC; j++)
                if (samples[k * BC + j] !== samples[k * BC]) consistent = 1'b0;
        end
        for (int k = 0; k < 8; k++) got = {got[6:0], samples[k * BC]};
        checkOutput("bitHold", int'(consistent), 1);
        checkOutput("frameByte", int'(got), int'(exByte));
`ifdef TRANSFER_PARITY_EN
        checkOutput("parityBit", int'(samples[8 * BC]), int'(^exByte));
`endif
    endtask

    // Monitor: every non-reset cycle is checked against the model and frames are rebuilt from active cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            inFrame   = 1'b0;
            seenFrame = 1'b0;
        end else begin
            checkOutput("busy", int'(bus.busy), (mPhase != 0) ? 1 : 0);
            checkOutput("readyOut", int'(bus.readyForTransferOut), (mPhase == 1) ? 1 : 0);
            checkOutput("grant", int'(bus.scanGrant), int'(mGrantExp));
            if (bus.readyForTransferOut) begin
                if (!inFrame) begin
                    inFrame  = 1'b1;
                    nS       = 0;
                    ownerBad = 1'b0;
                    frOwner  = bus.localScannerOut;
                    if (seenFrame) checkOutput("gapAtLeast2", (gap >= 2) ? 1 : 0, 1);
                end
                if (bus.localScannerOut != frOwner) ownerBad = 1'b1;
                if (bus.readyForTransferIn && nS < 64) begin
                    samples[nS] = bus.dataOut;
                    nS++;
                end
            end else begin
                checkOutput("idleData", int'(bus.dataOut), 0);
                checkOutput("idleOwner", int'(bus.localScannerOut), 0);
                if (inFrame) begin
                    inFrame   = 1'b0;
                    seenFrame = 1'b1;
                    gap       = 1;
                    frameCheck();
                end else begin
                    gap++;
                end
            end
        end
    end

    initial begin
        int d;
        bus.scanReq            = 2'b00;
        bus.scanByte0          = 8'd0;
        bus.scanByte1          = 8'd0;
        bus.readyForTransferIn = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkResetValues("initialReset");
        rst_n = 1'b1;
        bus.scanByte0          = 8'h0F;
        bus.scanByte1          = 8'hF0;
        bus.scanReq            = 2'b11;
        bus.readyForTransferIn = 1'b1;
        for (int c = 0; c < RUN_CYCLES; c++) begin
            stepCycle(1'b1);
            if (c == RUN_CYCLES / 2) injectReset();
        end
        d = 0;
        while ((mPhase != 0 || expFrameQ.size() != 0 || bus.scanReq != 2'b00) && d < 1000) begin
            stepCycle(1'b0);
            d++;
        end
        checkOutput("drainDone", (d < 1000) ? 1 : 0, 1);
        @(negedge clk);
        checkOutput("framesSeenMin", (framesSeen >= 20) ? 1 : 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/transfer_scheduler.md
# transfer_scheduler

Serial-link scheduler at the sending side of a scanner-to-transfer-center connection. Two local scanners post bytes; the block arbitrates round-robin between them and serialises the granted byte MSB-first onto the single `dataOut` line. It handshakes with the remote transfer center through `readyForTransferIn`/`readyForTransferOut` and tags each frame with the owning scanner on `localScannerOut`.

## Interface
- `BIT_CYCLES`, default 1: clock cycles each serial bit is held on `dataOut`; legal range 1–15.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `scanReq`  in  2  bit i high = scanner i has a byte pending; level, held until granted.
- `scanByte0`  in  8  scanner 0 byte; stable while `scanReq[0]` is high.
- `scanByte1`  in  8  scanner 1 byte; stable while `scanReq[1]` is high.
- `scanGrant`  out  2  one-hot, 1-cycle pulse: byte of scanner i captured.
- `readyForTransferIn`  in  1  remote center can accept or continue receiving.
- `readyForTransferOut`  out  1  high for every cycle a frame is on the wire.
- `dataOut`  out  1  serial data, MSB first.
- `localScannerOut`  out  2  one-hot owner of the current frame; 00 when idle.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, SEND, PAR (only with the parity macro), DONE.
- IDLE: at an edge with `scanReq` ≠ 00 and `readyForTransferIn` = 1, pick the winner, load an 8-bit shift register with its byte, pulse its `scanGrant` bit, set `localScannerOut`, and go to SEND. Otherwise stay.
- Arbitration: single requester wins. When both request, the scanner not served last wins. `lastServed` resets to 1, so scanner 0 wins the first tie. `lastServed` updates at capture.
- SEND: `dataOut` = shift register MSB. A 4-bit cycle counter advances only while `readyForTransferIn` = 1. When it reaches `BIT_CYCLES`−1, the register shifts left and the 3-bit bit counter increments. After bit 0 completes, go to DONE (or PAR).
- Stall: if `readyForTransferIn` = 0 in SEND or PAR, hold the current bit, both counters and `readyForTransferOut` = 1. Resume where stopped. There is no timeout.
- DONE: one cycle. `readyForTransferOut` = 0, `dataOut` = 0, `localScannerOut` = 00, then IDLE.
- A request arriving mid-frame waits. Requests are sampled only in IDLE.
- Reset mid-frame: all state clears immediately and the frame is abandoned. No re-grant; the scanner must keep `scanReq` high to be served again.

## Timing
- Reset values: `scanGrant` = 00, `readyForTransferOut` = 0, `dataOut` = 0, `localScannerOut` = 00, `busy` = 0, state IDLE, `lastServed` = 1, counters 0.
- All outputs are registered.
- Capture edge E0: in the cycle after E0, `scanGrant` is high for exactly one cycle, `readyForTransferOut` = 1, and `dataOut` = bit 7.
- No stall, `BIT_CYCLES` = 1: bits 7..0 occupy cycles 1–8 after E0, DONE is cycle 9, IDLE is cycle 10, and the earliest next frame starts in cycle 11.
- Frames are separated by at least 2 cycles with `readyForTransferOut` low.
- Frame length is 8 × `BIT_CYCLES` cycles plus stall cycles (9 × with parity).
- Scanners must drop `scanReq` within 8 cycles of the grant pulse, or the request is treated as a new byte.

## Configuration
- `TRANSFER_PARITY_EN` defined: after bit 0, enter PAR for `BIT_CYCLES` cycles (stallable). `dataOut` = XOR of the 8 captured bits (even parity) and `readyForTransferOut` stays high. Then DONE.
- Not defined: PAR state and parity logic are absent, and SEND goes directly to DONE.

## Test plan
- Single request: reset, `scanReq` = 01, `scanByte0` = 8'hA5, ready = 1 → `scanGrant` = 01 one cycle; `dataOut` = 1,0,1,0,0,1,0,1 on cycles 1–8; `localScannerOut` = 01; DONE in cycle 9.
- Tie round-robin: `scanReq` = 11 held with bytes 8'h0F and 8'hF0 → frame 0F (owner 01) then frame F0 (owner 10) with a 2-cycle gap. Re-raising both requests → scanner 0 is served next.
- Stall: during bit 4 of 8'hFF, drop ready for 3 cycles → `dataOut` and `readyForTransferOut` hold; frame ends 3 cycles late with all 8 bits emitted.
- `BIT_CYCLES` = 3 with 8'h81 → `dataOut` high for 3 cycles, low for 18, high for 3; DONE in cycle 25.
- Reset at bit 3 → all outputs go to reset values immediately; with `scanReq` still high and ready = 1, the same byte is re-sent from bit 7 after reset release.
- With `TRANSFER_PARITY_EN` and 8'h07 → cycle 9 `dataOut` = 1 with `readyForTransferOut` = 1; DONE in cycle 10.
